// File: rtl/rv32i_types.sv
// Shared RV32I datapath types plus the writeback arbiter's default sizing.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  // One regfile write request; used by both requesters and FIFO entries.
  typedef struct packed {
    logic      load;
    rv32i_reg  rd;
    rv32i_word data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } wb_grant_t;

  localparam int WB_STARVE_LIMIT = 4;
  localparam int WB_FIFO_DEPTH   = 2;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding MDU results until they win a regfile write slot.
module wb_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_entry,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full buffer is refused even if the head leaves this cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between the WB stage and buffered MDU
// results, forcing a one-cycle pipeline stall when a result waits too long.
module wb_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_load,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        stall_wb,
  output logic        rf_load,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic [31:0] pending
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t             pipe_req;
  wb_req_t             mdu_req;
  wb_req_t             fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  wb_grant_t           grant;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  logic                stall_next;
  logic [31:0]         pending_next;

  assign pipe_req  = '{load: wb_load, rd: wb_rd, data: wb_data};
  assign mdu_req   = '{load: 1'b1, rd: mdu_rd, data: mdu_data};
  assign mdu_ready = rst && !fifo_full;
  assign fifo_push = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign fifo_pop  = (grant == GRANT_FIFO);

  wb_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_entry(mdu_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // During a forced stall the pipeline request is ignored; it is re-presented next cycle.
  always_comb begin
    grant = GRANT_NONE;
    if (rst) begin
      if (stall_wb && !fifo_empty)
        grant = GRANT_FIFO;
      else if (!stall_wb && pipe_req.load && (pipe_req.rd != '0))
        grant = GRANT_PIPE;
      else if (!fifo_empty)
        grant = GRANT_FIFO;
    end
  end

  always_comb begin
    rf_load = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    case (grant)
      GRANT_PIPE: begin
        rf_load = 1'b1;
        rf_rd   = pipe_req.rd;
        rf_data = pipe_req.data;
      end
      GRANT_FIFO: begin
        rf_load = fifo_head.load;
        rf_rd   = fifo_head.rd;
        rf_data = fifo_head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || (grant == GRANT_FIFO))
      starve_next = '0;
    else if (starve_cnt < STARVE_W'(STARVE_LIMIT))
      starve_next = starve_cnt + STARVE_W'(1);
    stall_next = (starve_next == STARVE_W'(STARVE_LIMIT)) && !stall_wb;
  end

  // A new issue to the same register outranks the retiring result.
  always_comb begin
    pending_next = pending;
    if (grant == GRANT_FIFO) pending_next[fifo_head.rd] = 1'b0;
    if (mdu_issue)           pending_next[mdu_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_wb   <= 1'b0;
      pending    <= '0;
    end else begin
      starve_cnt <= starve_next;
      stall_wb   <= stall_next;
      pending    <= pending_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs.
module tb_wb_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int FIFO_DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_load = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        stall_wb;
  logic        rf_load;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] pending;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_load     (wb_load),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mdu_issue   (mdu_issue),
    .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .stall_wb    (stall_wb),
    .rf_load     (rf_load),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .pending     (pending)
  );

  typedef struct {
    int        cyc;
    bit        ready;
    bit        load;
    bit [4:0]  rd;
    bit [31:0] data;
    bit        stall;
    bit [31:0] pend;
  } exp_t;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } res_t;

  exp_t      exp_q[$];
  res_t      model_q[$];
  int        model_starve = 0;
  bit        model_stall  = 1'b0;
  bit [31:0] model_pend   = '0;
  int        checks = 0;
  int        errors = 0;
  int        cycle  = 0;

  // Reference model: buffered results are a plain queue, arbitration follows
  // the priority rules directly; expectations describe the cycle being driven.
  task automatic applyStimulus(input bit r, input bit wl, input bit [4:0] wr,
                               input bit [31:0] wd, input bit iss, input bit [4:0] ird,
                               input bit mv, input bit [4:0] mr, input bit [31:0] md);
    exp_t e;
    bit   pipe_ok;
    bit   fifo_g;
    bit   was_empty;
    @(negedge clk);
    rst = r; wb_load = wl; wb_rd = wr; wb_data = wd;
    mdu_issue = iss; mdu_issue_rd = ird; mdu_valid = mv; mdu_rd = mr; mdu_data = md;
    cycle++;
    e.cyc = cycle; e.stall = model_stall; e.pend = model_pend;
    e.ready = 1'b0; e.load = 1'b0; e.rd = '0; e.data = '0;
    if (!r) begin
      model_q.delete();
      model_starve = 0;
      model_stall  = 1'b0;
      model_pend   = '0;
    end else begin
      e.ready   = (model_q.size() < FIFO_DEPTH);
      pipe_ok   = wl && (wr != 0) && !model_stall;
      fifo_g    = (model_q.size() != 0) && (model_stall || !pipe_ok);
      was_empty = (model_q.size() == 0);
      if (fifo_g) begin
        e.load = 1'b1; e.rd = model_q[0].rd; e.data = model_q[0].data;
        model_pend[model_q[0].rd] = 1'b0;
        void'(model_q.pop_front());
      end else if (pipe_ok) begin
        e.load = 1'b1; e.rd = wr; e.data = wd;
      end
      if (mv && e.ready && (mr != 0)) model_q.push_back('{rd: mr, data: md});
      if (was_empty || fifo_g) model_starve = 0;
      else if (model_starve < STARVE_LIMIT) model_starve++;
      model_stall = (model_starve == STARVE_LIMIT) && !model_stall;
      if (iss && (ird != 0)) model_pend[ird] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want, input int cyc);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL cyc=%0d %s got 0x%08h want 0x%08h", cyc, name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("mdu_ready", 32'(mdu_ready), 32'(e.ready), e.cyc);
    compare("stall_wb",  32'(stall_wb),  32'(e.stall), e.cyc);
    compare("rf_load",   32'(rf_load),   32'(e.load),  e.cyc);
    compare("pending",   pending,        e.pend,       e.cyc);
    if (e.load) begin
      compare("rf_rd",   32'(rf_rd),     32'(e.rd),    e.cyc);
      compare("rf_data", rf_data,        e.data,       e.cyc);
    end
  endtask

  // Monitor samples mid-low-phase, after the driver has settled the inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd2, 1'b1, 5'd4, 32'h2);
    idle(1);

    // Single result on an idle pipeline.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h42);
    idle(2);

    // Busy pipeline starves a result until the forced stall.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 1'b1, 5'd7, 32'h777);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h301 + i, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Back-to-back results fill the buffer and back-pressure the MDU.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h400 + i, 1'b0, 5'd0, 1'b1, 5'(10 + i), 32'hA0 + i);
    idle(4);

    // Re-issue to the same register while its older result retires.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Result aimed at x0 is dropped.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEAD);
    idle(2);

    // Reset with two buffered entries outstanding.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h500, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h501, 1'b0, 5'd0, 1'b1, 5'd6, 32'h66);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h502, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88);
    idle(4);

    for (int i = 0; i < 800; i++)
      applyStimulus($urandom_range(99) >= 2, $urandom_range(99) < 65, 5'($urandom_range(31)), $urandom,
                    $urandom_range(99) < 30, 5'($urandom_range(31)),
                    $urandom_range(99) < 45, 5'($urandom_range(31)), $urandom);
    idle(12);

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles an MDU result may wait before a forced slot.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning MDU result buffer entries.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 wb_load  in  1  pipeline WB stage requests a regfile write.
REQ-006 wb_rd  in  5  pipeline WB destination register.
REQ-007 wb_data  in  32  pipeline WB write value (rv32i_word).
REQ-008 mdu_issue  in  1  multi-cycle multiply/divide op dispatched this cycle.
REQ-009 mdu_issue_rd  in  5  destination of the dispatched MDU op.
REQ-010 mdu_valid  in  1  MDU result available.
REQ-011 mdu_rd  in  5  MDU result destination.
REQ-012 mdu_data  in  32  MDU result value.
REQ-013 mdu_ready  out  1  arbiter accepts an MDU result this cycle.
REQ-014 stall_wb  out  1  freeze MEM/WB and upstream for one cycle.
REQ-015 rf_load  out  1  regfile write enable.
REQ-016 rf_rd  out  5  regfile write address.
REQ-017 rf_data  out  32  regfile write data.
REQ-018 pending  out  32  per-register MDU-result-outstanding scoreboard; bit 0 always 0.

Function
REQ-019 MDU result SHALL be accepted when mdu_valid and mdu_ready are both 1; mdu_ready = (registered count < FIFO_DEPTH), with no same-cycle pop credit.
REQ-020 Accepted results with mdu_rd = 0 SHALL be discarded, not enqueued.
REQ-021 Grant priority, combinational per cycle: (1) stall_wb = 1 and FIFO non-empty -> FIFO head; (2) wb_load = 1 and wb_rd != 0 -> pipeline; (3) FIFO non-empty -> FIFO head; (4) else rf_load = 0.
REQ-022 While stall_wb = 1, pipeline wb_* inputs SHALL be ignored; the pipeline holds them and they are presented again the following cycle.
REQ-023 A FIFO grant SHALL drive rf_load=1, rf_rd/rf_data from head and pop the head at the clock edge.
REQ-024 A result accepted in cycle t SHALL be writable no earlier than cycle t+1 (no bypass).
REQ-025 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-026 Starvation counter SHALL increment each cycle FIFO non-empty and not granted, saturating at STARVE_LIMIT; it SHALL clear on any FIFO grant or when FIFO is empty.
REQ-027 stall_wb SHALL be a registered one-cycle pulse, asserted the cycle after the counter reaches STARVE_LIMIT; never asserted two consecutive cycles.
REQ-028 pending[r] SHALL set at the edge where mdu_issue = 1 and mdu_issue_rd = r != 0.
REQ-029 pending[r] SHALL clear at the edge where a FIFO grant writes rd = r.
REQ-030 Simultaneous set and clear of the same bit: set SHALL win.
REQ-031 Pipeline grants SHALL never modify pending.
REQ-032 rf_load SHALL never be 1 with rf_rd = 0.

Reset
REQ-033 While rst = 0 at a rising edge: FIFO emptied, count 0, starvation counter 0, stall_wb 0, pending all 0.
REQ-034 While rst = 0: mdu_ready = 0 and rf_load = 0 regardless of inputs.
REQ-035 Reset mid-operation SHALL discard buffered MDU results and clear all pending bits with no regfile write.

Structure
REQ-036 rv32i_types SHALL gain a wb_req_t struct (load, rd[4:0], data rv32i_word) used for both requesters and FIFO entries.
REQ-037 STARVE_LIMIT and FIFO_DEPTH defaults SHALL be package constants.
REQ-038 FIFO SHALL be a separate sub-module wb_result_fifo (push/pop/full/empty/head, synchronous active-low reset).

Verification
REQ-039 Idle pipeline, mdu_valid with rd=5, data=0x0000_0042 at cycle 1 -> rf_load=1, rf_rd=5, rf_data=0x42 at cycle 2; pending[5] clears at cycle 2 edge.
REQ-040 wb_load every cycle rd=3, one MDU result rd=7 queued -> pipeline granted 4 cycles, stall_wb=1 on 5th cycle, rd=7 written that cycle, wb rd=3 rewritten in cycle 6.
REQ-041 Two MDU results back-to-back while pipeline busy -> mdu_ready=0 on third cycle; third result accepted only after a pop.
REQ-042 mdu_issue rd=9 and FIFO write of rd=9 in the same cycle -> pending[9] remains 1.
REQ-043 mdu_valid with rd=0 -> no enqueue, rf_load never asserted for it.
REQ-044 rst=0 for one cycle with two queued entries and pending[4]=1 -> FIFO empty, pending=0, no write to rd=4 afterward.
